// File: rtl/sdrc_wb_traffic_gen_if.sv
// Wishbone master/slave bundle between the SDRAM traffic generator and the
// sdrc_top Wishbone slave port.
interface sdrc_wb_traffic_gen_if #(
  parameter int DW = 32,
  parameter int AW = 30
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst traffic generator/checker for SDRAM bring-up: LFSR write data,
// independently stepped LFSR for read-back checking, descriptor FIFO between phases.
module sdrc_wb_traffic_gen #(
  parameter int DW    = 32,
  parameter int AW    = 30,
  parameter int BL_W  = 8,
  parameter int NB_W  = 16,
  parameter int DEPTH = 8,
  parameter int TO_W  = 12
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  sdrc_wb_traffic_gen_if.master wb,
  input  logic                 start,
  input  logic                 cfg_mode,
  input  logic [AW-1:0]        cfg_start_addr,
  input  logic [AW-1:0]        cfg_stride,
  input  logic [BL_W-1:0]      cfg_burst_len,
  input  logic                 cfg_len_rand,
  input  logic [BL_W-1:0]      cfg_len_mask,
  input  logic [NB_W-1:0]      cfg_num_bursts,
  input  logic [31:0]          cfg_seed,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          err_cnt,
  output logic [AW-1:0]        first_err_addr,
  output logic [DW-1:0]        first_err_exp,
  output logic [DW-1:0]        first_err_rcv
);
  localparam int LEN_W = BL_W + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Counter value one short of all-ones: the no-ack edge seen here is the one that reaches 2^TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_WGAP, ST_RD, ST_RGAP, ST_DONE} state_t;
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
  } desc_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  state_t            state;
  logic              cyc_q, stb_q, we_q;
  logic [AW-1:0]     addr_q, next_addr, stride_q;
  logic [2:0]        cti_q;
  logic [31:0]       wr_lfsr, rd_lfsr, len_lfsr;
  logic [LEN_W-1:0]  beats_left;
  logic [TO_W-1:0]   to_cnt;
  logic [NB_W-1:0]   wr_cnt, rd_cnt, num_q;
  logic              mode_q, rand_q;
  logic [BL_W-1:0]   len_q, mask_q;

  desc_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fcnt;

  logic [31:0]       seed_fix, len_base;
  logic [BL_W-1:0]   use_mask, use_bl;
  logic              use_rand, idle, fifo_full, fifo_empty, to_hit;
  logic              launch_wr, launch_rd;
  logic [LEN_W-1:0]  new_len;
  logic [AW-1:0]     burst_addr, burst_stride;
  desc_t             head;

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = wr_lfsr[DW-1:0];
  assign wb.wb_sel_o  = '1;
  assign wb.wb_cti_o  = cti_q;

  // NOTE: every always_comb output is assigned up front so no path can infer a latch.
  always_comb begin
    seed_fix     = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    idle         = (state == ST_IDLE);
    // While idle the config registers are not loaded yet, so the first burst uses the live inputs.
    len_base     = idle ? ~seed_fix : len_lfsr;
    use_rand     = idle ? cfg_len_rand : rand_q;
    use_mask     = idle ? cfg_len_mask : mask_q;
    use_bl       = idle ? cfg_burst_len : len_q;
    burst_addr   = idle ? cfg_start_addr : next_addr;
    burst_stride = idle ? cfg_stride : stride_q;
    if (use_rand)            new_len = {1'b0, len_base[BL_W-1:0] & use_mask} + LEN_W'(1);
    else if (use_bl == '0)   new_len = LEN_W'(1);
    else                     new_len = {1'b0, use_bl};
    fifo_full  = (fcnt == CNT_W'(DEPTH));
    fifo_empty = (fcnt == '0);
    head       = fifo_mem[rd_ptr];
    to_hit     = !wb.wb_ack_i && (to_cnt == TO_LAST);
    launch_wr  = 1'b0;
    launch_rd  = 1'b0;
    case (state)
      ST_IDLE: launch_wr = start && (cfg_num_bursts != '0);
      ST_WGAP: begin
        launch_wr = !mode_q && (wr_cnt != num_q) && !fifo_full;
        launch_rd = !launch_wr;
      end
      ST_RGAP: if (rd_cnt != num_q) begin
        launch_wr = mode_q || fifo_empty;
        launch_rd = !launch_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state == ST_DONE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (launch_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (launch_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (launch_wr)      fcnt <= fcnt + 1'b1;
      else if (launch_rd) fcnt <= fcnt - 1'b1;
    end
  end

  // NOTE: descriptor storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge wb_clk_i) begin
    if (launch_wr) fifo_mem[wr_ptr] <= '{addr: burst_addr, len: new_len};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      cyc_q <= 1'b0;  stb_q <= 1'b0;  we_q <= 1'b0;  cti_q <= 3'b000;
      addr_q <= '0;   next_addr <= '0; stride_q <= '0;
      wr_lfsr <= '0;  rd_lfsr <= '0;   len_lfsr <= '0;
      beats_left <= '0; to_cnt <= '0;
      wr_cnt <= '0;   rd_cnt <= '0;    num_q <= '0;
      mode_q <= 1'b0; rand_q <= 1'b0;  len_q <= '0; mask_q <= '0;
      busy <= 1'b0;   done <= 1'b0;    timeout <= 1'b0; err_cnt <= '0;
      first_err_addr <= '0; first_err_exp <= '0; first_err_rcv <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          mode_q   <= cfg_mode;      stride_q <= cfg_stride;
          len_q    <= cfg_burst_len; rand_q   <= cfg_len_rand;
          mask_q   <= cfg_len_mask;  num_q    <= cfg_num_bursts;
          wr_lfsr  <= seed_fix;      rd_lfsr  <= seed_fix;
          rd_cnt   <= '0;
          done     <= 1'b0;          timeout  <= 1'b0;   err_cnt <= '0;
          first_err_addr <= '0; first_err_exp <= '0; first_err_rcv <= '0;
          if (cfg_num_bursts == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        ST_WR, ST_RD: begin
          if (to_hit) begin
            timeout <= 1'b1;
            cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0; cti_q <= 3'b000;
            busy <= 1'b0;  done <= 1'b1;  state <= ST_DONE;
          end else if (wb.wb_ack_i) begin
            to_cnt <= '0;
            addr_q <= addr_q + 1'b1;
            if (state == ST_WR) begin
              wr_lfsr <= lfsr_step(wr_lfsr);
            end else begin
              rd_lfsr <= lfsr_step(rd_lfsr);
              if (wb.wb_dat_i != rd_lfsr[DW-1:0]) begin
                if (err_cnt == '0) begin
                  first_err_addr <= addr_q;
                  first_err_exp  <= rd_lfsr[DW-1:0];
                  first_err_rcv  <= wb.wb_dat_i;
                end
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
              end
            end
            if (beats_left == LEN_W'(1)) begin
              cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0; cti_q <= 3'b000;
              if (state == ST_WR) begin
                state <= ST_WGAP;
              end else begin
                state  <= ST_RGAP;
                rd_cnt <= rd_cnt + 1'b1;
              end
            end else begin
              beats_left <= beats_left - 1'b1;
              cti_q      <= (beats_left == LEN_W'(2)) ? 3'b111 : 3'b010;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RGAP: if (rd_cnt == num_q) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Burst launches override the state's own next-state choice.
      if (launch_wr) begin
        cyc_q <= 1'b1; stb_q <= 1'b1; we_q <= 1'b1;
        addr_q     <= burst_addr;
        next_addr  <= burst_addr + burst_stride;
        beats_left <= new_len;
        cti_q      <= (new_len == LEN_W'(1)) ? 3'b111 : 3'b010;
        to_cnt     <= '0;
        len_lfsr   <= lfsr_step(len_base);
        wr_cnt     <= (idle ? '0 : wr_cnt) + NB_W'(1);
        state      <= ST_WR;
      end else if (launch_rd) begin
        cyc_q <= 1'b1; stb_q <= 1'b1; we_q <= 1'b0;
        addr_q     <= head.addr;
        beats_left <= head.len;
        cti_q      <= (head.len == LEN_W'(1)) ? 3'b111 : 3'b010;
        to_cnt     <= '0;
        state      <= ST_RD;
      end
    end
  end
endmodule

// File: doc/sdrc_wb_traffic_gen.md
Name: sdrc_wb_traffic_gen

Overview:
Synthesisable Wishbone master that generates and checks SDRAM burst write/read traffic for bring-up and BIST. It connects to the sdrc_top Wishbone slave port in place of a host. Write data comes from a seeded LFSR; expected read data comes from an identical, independently stepped LFSR. Burst descriptors (address, length) are queued in a parametrised FIFO so several bursts can be written before they are read back.

Parameters:
DW, 32, Wishbone data width; legal values 8, 16, 32; data is lfsr[DW-1:0].
AW, 30, Wishbone word address width.
BL_W, 8, burst length field width.
NB_W, 16, burst count width.
DEPTH, 8, descriptor FIFO depth; power of 2, at least 1.
TO_W, 12, ack-timeout counter width.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
start  in  1  1-cycle start pulse; sampled only in IDLE
cfg_mode  in  1  0 = BATCH, 1 = INTERLEAVE
cfg_start_addr  in  AW  first burst word address
cfg_stride  in  AW  address increment between burst start addresses
cfg_burst_len  in  BL_W  fixed burst length; 0 is treated as 1
cfg_len_rand  in  1  1 = length is (len_lfsr[BL_W-1:0] & cfg_len_mask) + 1
cfg_len_mask  in  BL_W  random length mask
cfg_num_bursts  in  NB_W  bursts to run; 0 means done immediately
cfg_seed  in  32  data LFSR seed; 0 is replaced by 1
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls
wb_addr_o  out  AW  word address
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte enables; always all ones
wb_cti_o  out  3  cycle type identifier
wb_dat_i  in  DW  read data
wb_ack_i  in  1  acknowledge
busy  out  1  high from the cycle after start until DONE
done  out  1  level; set at completion, cleared by the next accepted start
timeout  out  1  sticky ack-timeout flag
err_cnt  out  16  saturating count of read miscompares
first_err_addr  out  AW  address of the first miscompare
first_err_exp  out  DW  expected data at the first miscompare
first_err_rcv  out  DW  received data at the first miscompare

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; FIFO is emptied. Reset takes effect on the next edge even mid-burst, with cyc/stb low after that edge.
- FSM states: IDLE, WR, WGAP, RD, RGAP, DONE.
- IDLE + start:
  - Latch all cfg_* inputs.
  - Load the write LFSR and read LFSR with the seed, and the length LFSR with ~seed.
  - Go to WR; cyc/stb/we assert on the next cycle (latency 1).
  - If cfg_num_bursts = 0, go directly to DONE.
- Descriptor generation: burst k starts at start_addr + k*stride, modulo 2^AW. Its length is computed once and pushed to the FIFO when the burst's first beat is presented.
- Beats:
  - stb and cyc stay high for the whole burst.
  - On each ack edge: addr increments by 1 (wraps at 2^AW) and the relevant LFSR steps. The next beat is presented the following cycle with no idle cycle.
  - cti = 3'b010 on non-final beats, 3'b111 on the final beat. A 1-beat burst uses 3'b111.
- Gaps: after the last ack of a burst, cyc/stb drop for exactly one cycle (WGAP/RGAP).
- BATCH mode: keep issuing write bursts until the FIFO is full or all bursts are issued. Then pop and read back until the FIFO is empty. Repeat until all bursts are read, then go to DONE.
- INTERLEAVE mode: write 1 burst, then read it back; FIFO occupancy never exceeds 1.
- Check: on each read ack, compare wb_dat_i with read_lfsr[DW-1:0].
  - On mismatch, err_cnt increments and saturates at 0xFFFF.
  - The first_err_* registers capture only on the first miscompare.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, stepped once per acked beat.
- Timeout: counter clears on every ack and counts while stb is high. When it reaches 2^TO_W-1:
  - set timeout;
  - drop cyc/stb;
  - go to DONE without reading the rest.
- DONE: done=1, busy=0; return to IDLE on the same cycle. A start arriving while busy is ignored.
- The ack-to-stb relation is combinational from the slave's side. An ack while stb is low is ignored.

Test Plan:
- seed=1, mode=BATCH, len=4, num=2, start=0x10000, stride=0x4000, ideal 1-cycle slave memory -> 8 write beats at 0x10000..3 and 0x14000..3, then 8 reads at the same addresses; cti sequence 2,2,2,7 per burst; err_cnt=0; done=1.
- DEPTH=8, num=20, BATCH mode -> write/read phases of 8, 8, 4 bursts; FIFO never overflows; err_cnt=0.
- Slave corrupts bit 0 of the 3rd read beat -> err_cnt=1; first_err_addr = start+2; first_err_exp ^ first_err_rcv = 1.
- Slave never acks -> timeout=1 after 4095 stb cycles; cyc=0; done=1.
- wb_rst_i asserted mid-burst -> cyc/stb/busy/err_cnt are 0 after the next edge; a new start runs cleanly.
- Corner cases:
  - cfg_len_rand=1 with mask=0x3F produces lengths 1..64 and still passes.
  - cfg_burst_len=0 runs 1-beat bursts.
  - start_addr=2^AW-2 with len=4 wraps the address to 0.
  - seed=0 behaves exactly as seed=1.
